// File: rtl/bootram_bridge_pkg.sv
// Shared types and constants for the PicoRV32-to-boot-RAM word bridge.
package bootram_bridge_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = 2;

  // Lane index of the most significant byte of a word.
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } bridge_state_t;

endpackage

// File: rtl/bootram_word_bridge.sv
// Splits each 32-bit PicoRV32 memory access into four byte accesses on a
// 2^ADDR_WIDTH x 8 single-port boot RAM, little-endian lane order.
//
// Handshake: a request is taken only in IDLE, on a clock edge where
// mem_valid & sel are both high; address, data and strobes are latched then
// and the CPU side is ignored until mem_ready has pulsed high for exactly one
// cycle (DONE). mem_rdata is valid while mem_ready is high and otherwise
// holds the last captured read word. Dropping mem_valid early does not abort.
//
// RAM_LATENCY must be 1 (bypass read mode) or 2 (pipeline read mode).
// Every ram_* output is driven straight from a flop or a constant.
module bootram_word_bridge
  import bootram_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH  = 11,
  parameter int RAM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  sel,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic [31:0]           mem_rdata,
  output logic                  ram_ce,
  output logic                  ram_oce,
  output logic                  ram_reset,
  output logic                  ram_wre,
  output logic [ADDR_WIDTH-1:0] ram_ad,
  output logic [7:0]            ram_din,
  input  logic [7:0]            ram_dout,
  output bridge_state_t         dbg_state
);

  localparam int WORD_AW = ADDR_WIDTH - 2;

  bridge_state_t       state, nxt_state;
  logic [LANE_W-1:0]   cnt, nxt_cnt;
  logic                rd_issue, nxt_issue;
  logic [WORD_AW-1:0]  word_addr;
  logic [31:0]         wdata_q;
  logic [3:0]          wstrb_q;

  logic                accept;
  logic [WORD_AW-1:0]  nxt_word;
  logic [31:0]         nxt_wdata;
  logic [3:0]          nxt_wstrb;

  logic                nxt_ce, nxt_wre, nxt_ready;
  logic [ADDR_WIDTH-1:0] nxt_ad;
  logic [7:0]          nxt_din;

  // Capture lane delay line: one entry per in-flight read byte.
  logic [RAM_LATENCY-1:0] cap_vld;
  logic [LANE_W-1:0]      cap_lane [RAM_LATENCY];
  logic                   capture;
  logic [LANE_W-1:0]      capture_lane;

  // Address bits outside the RAM word range are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:ADDR_WIDTH], mem_addr[1:0]};

  assign accept       = (state == IDLE) && mem_valid && sel;
  assign capture      = cap_vld[RAM_LATENCY-1];
  assign capture_lane = cap_lane[RAM_LATENCY-1];

  // On acceptance the fresh request feeds the next-cycle RAM drive directly.
  assign nxt_word  = accept ? mem_addr[ADDR_WIDTH-1:2] : word_addr;
  assign nxt_wdata = accept ? mem_wdata : wdata_q;
  assign nxt_wstrb = accept ? mem_wstrb : wstrb_q;

  assign ram_oce   = 1'b1;
  assign ram_reset = 1'b0;
  assign dbg_state = state;

  // State register: FSM state, byte counter and read-issue flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      rd_issue <= 1'b0;
    end else begin
      state    <= nxt_state;
      cnt      <= nxt_cnt;
      rd_issue <= nxt_issue;
    end
  end

  // Next-state logic: writes walk four lanes, reads run until lane 3 lands.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_issue = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          nxt_cnt   = '0;
          nxt_state = (mem_wstrb != 4'b0000) ? WR : RD;
          nxt_issue = (mem_wstrb == 4'b0000);
        end
      end
      WR: begin
        nxt_cnt = cnt + LANE_W'(1);
        if (cnt == LAST_LANE) nxt_state = DONE;
      end
      RD: begin
        if (rd_issue && (cnt != LAST_LANE)) begin
          nxt_cnt   = cnt + LANE_W'(1);
          nxt_issue = 1'b1;
        end
        if (capture && (capture_lane == LAST_LANE)) nxt_state = DONE;
      end
      DONE:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // Output logic: RAM drive and ready pulse for the cycle after this edge.
  always_comb begin
    nxt_ce    = 1'b0;
    nxt_wre   = 1'b0;
    nxt_ad    = ram_ad;
    nxt_din   = ram_din;
    nxt_ready = (nxt_state == DONE);
    case (nxt_state)
      WR: begin
        nxt_ad  = {nxt_word, nxt_cnt};
        nxt_din = nxt_wdata[{nxt_cnt, 3'b000} +: 8];
        nxt_ce  = nxt_wstrb[nxt_cnt];
        nxt_wre = nxt_wstrb[nxt_cnt];
      end
      RD: begin
        if (nxt_issue) begin
          nxt_ad = {nxt_word, nxt_cnt};
          nxt_ce = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Request latch: word address, write data and strobes held for the access.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      word_addr <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else if (accept) begin
      word_addr <= mem_addr[ADDR_WIDTH-1:2];
      wdata_q   <= mem_wdata;
      wstrb_q   <= mem_wstrb;
    end
  end

  // Output registers for the RAM port and the CPU ready pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ram_ce    <= 1'b0;
      ram_wre   <= 1'b0;
      ram_ad    <= '0;
      ram_din   <= '0;
      mem_ready <= 1'b0;
    end else begin
      ram_ce    <= nxt_ce;
      ram_wre   <= nxt_wre;
      ram_ad    <= nxt_ad;
      ram_din   <= nxt_din;
      mem_ready <= nxt_ready;
    end
  end

  // Lane delay line: tags each issued read so its byte is captured on return.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cap_vld <= '0;
      for (int i = 0; i < RAM_LATENCY; i++) cap_lane[i] <= '0;
    end else begin
      cap_vld[0]  <= (state == RD) && rd_issue;
      cap_lane[0] <= cnt;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        cap_vld[i]  <= cap_vld[i-1];
        cap_lane[i] <= cap_lane[i-1];
      end
    end
  end

  // Read word assembly: returning byte lands in its lane, others hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_rdata <= '0;
    end else if (capture) begin
      mem_rdata[{capture_lane, 3'b000} +: 8] <= ram_dout;
    end
  end

endmodule

// File: tb/tb_bootram_word_bridge.sv
// Directed bench: two bridges (read latency 1 and 2) share the CPU-side
// stimulus, each with its own behavioural 2K x 8 boot RAM.
module tb_bootram_word_bridge;
  import bootram_bridge_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared CPU side ----------------
  logic        sel_a = 1'b0, sel_b = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr  = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;

  // ---------------- DUT A (latency 1) ----------------
  logic        mem_ready_a, ram_ce_a, ram_oce_a, ram_reset_a, ram_wre_a;
  logic [31:0] mem_rdata_a;
  logic [10:0] ram_ad_a;
  logic [7:0]  ram_din_a, ram_dout_a;
  bridge_state_t dbg_state_a;

  bootram_word_bridge #(.ADDR_WIDTH(11), .RAM_LATENCY(1)) dut_a (
    .clk(clk), .resetn(resetn), .sel(sel_a), .mem_valid(mem_valid),
    .mem_ready(mem_ready_a), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata_a), .ram_ce(ram_ce_a),
    .ram_oce(ram_oce_a), .ram_reset(ram_reset_a), .ram_wre(ram_wre_a),
    .ram_ad(ram_ad_a), .ram_din(ram_din_a), .ram_dout(ram_dout_a),
    .dbg_state(dbg_state_a)
  );

  // ---------------- DUT B (latency 2) ----------------
  logic        mem_ready_b, ram_ce_b, ram_oce_b, ram_reset_b, ram_wre_b;
  logic [31:0] mem_rdata_b;
  logic [10:0] ram_ad_b;
  logic [7:0]  ram_din_b, ram_dout_b;
  bridge_state_t dbg_state_b;

  bootram_word_bridge #(.ADDR_WIDTH(11), .RAM_LATENCY(2)) dut_b (
    .clk(clk), .resetn(resetn), .sel(sel_b), .mem_valid(mem_valid),
    .mem_ready(mem_ready_b), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata_b), .ram_ce(ram_ce_b),
    .ram_oce(ram_oce_b), .ram_reset(ram_reset_b), .ram_wre(ram_wre_b),
    .ram_ad(ram_ad_b), .ram_din(ram_din_b), .ram_dout(ram_dout_b),
    .dbg_state(dbg_state_b)
  );

  // ---------------- behavioural boot RAMs ----------------
  logic [7:0] ram_a [2048];
  logic [7:0] ram_b [2048];
  logic [7:0] dq_a = '0, dq_b = '0, dq_b2 = '0;

  always @(posedge clk) begin
    if (ram_ce_a) begin
      if (ram_wre_a) ram_a[ram_ad_a] <= ram_din_a;
      else           dq_a <= ram_a[ram_ad_a];
    end
  end
  assign ram_dout_a = dq_a;

  always @(posedge clk) begin
    if (ram_ce_b) begin
      if (ram_wre_b) ram_b[ram_ad_b] <= ram_din_b;
      else           dq_b <= ram_b[ram_ad_b];
    end
    if (ram_oce_b) dq_b2 <= dq_b;
  end
  assign ram_dout_b = dq_b2;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- per-transaction records ----------------
  int          rdy_cyc_a, rdy_cyc_b, rdy_cnt_a, rdy_cnt_b;
  logic [31:0] rdata_a, rdata_b;
  logic        ce_rec  [0:10];
  logic        wre_rec [0:10];
  logic [10:0] ad_rec  [0:10];
  bridge_state_t st_after_a, st_after_b;

  // Drive one request (acceptance edge = cycle 0) and record 10 cycles.
  // hold=1 keeps mem_valid/sel high until the cycle after each DUT's DONE.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input bit hold);
    rdy_cyc_a = 0; rdy_cyc_b = 0; rdy_cnt_a = 0; rdy_cnt_b = 0;
    rdata_a = '0; rdata_b = '0;
    st_after_a = IDLE; st_after_b = IDLE;
    @(negedge clk);
    mem_valid = 1'b1; sel_a = 1'b1; sel_b = 1'b1;
    mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (!hold && c == 1) begin
        mem_valid = 1'b0; sel_a = 1'b0; sel_b = 1'b0;
      end
      if (hold && rdy_cnt_a > 0 && c == rdy_cyc_a + 1) begin
        st_after_a = dbg_state_a; sel_a = 1'b0;
      end
      if (hold && rdy_cnt_b > 0 && c == rdy_cyc_b + 1) begin
        st_after_b = dbg_state_b; sel_b = 1'b0;
      end
      ce_rec[c] = ram_ce_a; wre_rec[c] = ram_wre_a; ad_rec[c] = ram_ad_a;
      if (mem_ready_a) begin rdy_cnt_a++; rdy_cyc_a = c; rdata_a = mem_rdata_a; end
      if (mem_ready_b) begin rdy_cnt_b++; rdy_cyc_b = c; rdata_b = mem_rdata_b; end
    end
    mem_valid = 1'b0; sel_a = 1'b0; sel_b = 1'b0; mem_wstrb = '0;
    if (!hold) begin
      st_after_a = dbg_state_a; st_after_b = dbg_state_b;
    end
  endtask

  task automatic check_read(input string tag, input logic [31:0] exp);
    check({tag, " rdata_a"}, rdata_a, exp);
    check({tag, " rdata_b"}, rdata_b, exp);
    check({tag, " ready_cycle_a"}, rdy_cyc_a, 6);
    check({tag, " ready_cycle_b"}, rdy_cyc_b, 7);
    check({tag, " ready_count_a"}, rdy_cnt_a, 1);
    check({tag, " ready_count_b"}, rdy_cnt_b, 1);
  endtask

  task automatic check_write(input string tag);
    check({tag, " ready_cycle_a"}, rdy_cyc_a, 5);
    check({tag, " ready_cycle_b"}, rdy_cyc_b, 5);
    check({tag, " ready_count_a"}, rdy_cnt_a, 1);
    check({tag, " ready_count_b"}, rdy_cnt_b, 1);
  endtask

  // Watchdog in case a wait on the DUT never resolves.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed test sequence ----------------
  initial begin
    int extra;
    logic [10:0] exp_ad;

    // 1. reset values
    repeat (3) @(negedge clk);
    check("rst mem_ready_a", mem_ready_a, 0);
    check("rst mem_ready_b", mem_ready_b, 0);
    check("rst ram_ce", ram_ce_a, 0);
    check("rst ram_wre", ram_wre_a, 0);
    check("rst ram_ad", ram_ad_a, 0);
    check("rst ram_din", ram_din_a, 0);
    check("rst mem_rdata_a", mem_rdata_a, 32'h0);
    check("rst mem_rdata_b", mem_rdata_b, 32'h0);
    check("rst ram_oce", ram_oce_a, 1);
    check("rst ram_reset", ram_reset_a, 0);
    check("rst state", 32'(dbg_state_a), 32'(IDLE));
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // 2. full-word write
    run_txn(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0);
    check_write("wr_full");
    check("wr_full ram_a[10]", 32'(ram_a[16]), 32'hEF);
    check("wr_full ram_a[11]", 32'(ram_a[17]), 32'hBE);
    check("wr_full ram_a[12]", 32'(ram_a[18]), 32'hAD);
    check("wr_full ram_a[13]", 32'(ram_a[19]), 32'hDE);
    check("wr_full ram_b[13]", 32'(ram_b[19]), 32'hDE);
    for (int c = 1; c <= 4; c++) begin
      exp_ad = 11'h010 + 11'(c - 1);
      check("wr_full ram_ad", 32'(ad_rec[c]), 32'(exp_ad));
      check("wr_full ram_wre", 32'(wre_rec[c]), 1);
    end
    check("wr_full ram_ce c5", 32'(ce_rec[5]), 0);

    // 3. read back, both latencies
    run_txn(32'h0000_0010, 32'h0, 4'h0, 1'b0);
    check_read("rd_full", 32'hDEAD_BEEF);
    for (int c = 1; c <= 4; c++) begin
      check("rd_full ram_ce", 32'(ce_rec[c]), 1);
      check("rd_full ram_wre", 32'(wre_rec[c]), 0);
    end
    check("rd_full ram_ce c5", 32'(ce_rec[5]), 0);
    check("rd_full state after", 32'(st_after_a), 32'(IDLE));

    // 4. single-lane strobe
    run_txn(32'h0000_0010, 32'h0055_0000, 4'b0100, 1'b0);
    check_write("wr_lane2");
    check("wr_lane2 ram_ce c1", 32'(ce_rec[1]), 0);
    check("wr_lane2 ram_ce c2", 32'(ce_rec[2]), 0);
    check("wr_lane2 ram_ce c3", 32'(ce_rec[3]), 1);
    check("wr_lane2 ram_ce c4", 32'(ce_rec[4]), 0);
    check("wr_lane2 ram_a[10]", 32'(ram_a[16]), 32'hEF);
    check("wr_lane2 ram_a[11]", 32'(ram_a[17]), 32'hBE);
    check("wr_lane2 ram_a[12]", 32'(ram_a[18]), 32'h55);
    check("wr_lane2 ram_a[13]", 32'(ram_a[19]), 32'hDE);
    check("wr_lane2 rdata kept a", mem_rdata_a, 32'hDEAD_BEEF);
    check("wr_lane2 rdata kept b", mem_rdata_b, 32'hDEAD_BEEF);
    run_txn(32'h0000_0010, 32'h0, 4'h0, 1'b0);
    check_read("rd_lane2", 32'hDE55_BEEF);

    // 5. top-of-RAM word via wrapped address, valid held through DONE
    run_txn(32'h0000_07FC, 32'h0403_0201, 4'hF, 1'b0);
    check_write("wr_top");
    run_txn(32'hFFFF_F7FE, 32'h0, 4'h0, 1'b1);
    check_read("rd_wrap", 32'h0403_0201);
    for (int c = 1; c <= 4; c++) begin
      exp_ad = 11'h7FC + 11'(c - 1);
      check("rd_wrap ram_ad", 32'(ad_rec[c]), 32'(exp_ad));
    end
    check("rd_wrap no reaccept a", 32'(st_after_a), 32'(IDLE));
    check("rd_wrap no reaccept b", 32'(st_after_b), 32'(IDLE));

    // 6. reset in cycle 3 of a read
    @(negedge clk);
    mem_valid = 1'b1; sel_a = 1'b1; sel_b = 1'b1;
    mem_addr = 32'h0000_0010; mem_wstrb = 4'h0;
    @(posedge clk);
    @(negedge clk);
    mem_valid = 1'b0; sel_a = 1'b0; sel_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("midrst state a", 32'(dbg_state_a), 32'(IDLE));
    check("midrst state b", 32'(dbg_state_b), 32'(IDLE));
    check("midrst ram_ce", ram_ce_a, 0);
    check("midrst mem_ready", mem_ready_a, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    extra = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mem_ready_a || mem_ready_b) extra++;
    end
    check("midrst no ready", extra, 0);
    check("midrst idle a", 32'(dbg_state_a), 32'(IDLE));
    check("midrst idle b", 32'(dbg_state_b), 32'(IDLE));
    run_txn(32'h0000_0010, 32'h0, 4'h0, 1'b0);
    check_read("rd_after_rst", 32'hDE55_BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bootram_word_bridge.md
# bootram_word_bridge

Adapts the PicoRV32 32-bit native memory interface to the 2K×8 single-port boot RAM. Each CPU word access becomes four sequential byte accesses on the RAM port. Read bytes are assembled into a 32-bit word, and write strobes are honoured per byte. The bridge sits between the SoC address decoder (which supplies `sel`) and the boot RAM instance, and is the only RAM master.

## Interface
Parameters:
- `ADDR_WIDTH`, 11: RAM byte-address width; RAM size is 2^ADDR_WIDTH bytes.
- `RAM_LATENCY`, 1: cycles from a RAM read issue to valid `ram_dout`. Legal values are 1 (bypass read mode) and 2 (pipeline read mode).

Ports:
- `clk`, in, 1: single clock.
- `resetn`, in, 1: asynchronous, active-low reset.
- `sel`, in, 1: address decoder hit for this RAM.
- `mem_valid`, in, 1: CPU request.
- `mem_ready`, out, 1: one-cycle completion pulse.
- `mem_addr`, in, 32: byte address. Bits [1:0] are ignored; only [ADDR_WIDTH-1:2] are used.
- `mem_wdata`, in, 32: write data.
- `mem_wstrb`, in, 4: byte write enables. 0 means a read.
- `mem_rdata`, out, 32: read word; valid while `mem_ready`=1.
- `ram_ce`, out, 1: RAM clock enable.
- `ram_oce`, out, 1: RAM output clock enable; constant 1.
- `ram_reset`, out, 1: RAM output reset; constant 0.
- `ram_wre`, out, 1: RAM write enable.
- `ram_ad`, out, ADDR_WIDTH: RAM byte address.
- `ram_din`, out, 8: RAM write byte.
- `ram_dout`, in, 8: RAM read byte.

## Operation
- States are IDLE, RD, WR and DONE.
- **IDLE.** When `mem_valid & sel`, latch the word address, `mem_wdata` and `mem_wstrb`, and clear the 2-bit byte counter. Go to WR if `mem_wstrb`≠0, otherwise go to RD. Never accept a request in any other state.
- **WR.** Spend 4 cycles, byte k = counter value, little-endian.
  - `ram_ad` = {word_addr, k}.
  - `ram_din` = wdata[8k+7:8k].
  - `ram_ce` = `ram_wre` = wstrb[k]. A disabled byte still consumes its cycle, so there is no skipping.
  - After k=3, go to DONE.
- **RD.** Issue 4 byte reads on consecutive cycles with `ram_ce`=1 and `ram_wre`=0.
  - Capture `ram_dout` RAM_LATENCY cycles after each issue into mem_rdata[8k+7:8k], using a delayed copy of the counter as lane index.
  - Stay in RD until the last capture completes, then go to DONE.
- **DONE.** Assert `mem_ready` for exactly one cycle, then return to IDLE. `mem_rdata` holds its value until the next read capture.
- Write transactions leave `mem_rdata` unchanged.
- If `mem_valid` is dropped mid-transaction (a protocol violation), the transaction still completes and `mem_ready` still pulses.
- Back-to-back requests: the earliest next acceptance is the cycle after DONE (IDLE). A `mem_valid` still high during DONE is not re-accepted.
- Address wrap: upper address bits are discarded, so 0xFFFF_F7FC maps to bytes 0x7FC–0x7FF.
- Reset, including mid-transaction: state goes to IDLE immediately. Any ongoing write is cut short; bytes already written stay written.

## Timing
- Reset values:
  - `mem_ready`=0, `mem_rdata`=0.
  - `ram_ce`=0, `ram_wre`=0, `ram_ad`=0, `ram_din`=0.
  - `ram_oce`=1, `ram_reset`=0.
- Acceptance edge is cycle 0.
- Write: RAM write cycles are 1–4, and `mem_ready` is high in cycle 5.
- Read: issue cycles are 1–4. The last capture happens at the end of cycle 4+RAM_LATENCY. `mem_ready` is high in cycle 5+RAM_LATENCY, i.e. cycle 6 for latency 1 and cycle 7 for latency 2.
- All outputs are registered or constant; there is no combinational path from `mem_*` inputs to `ram_*` outputs.

## Structure
- Package `bootram_bridge_pkg` contains:
  - the state enum `bridge_state_t` (IDLE, RD, WR, DONE);
  - `BYTES_PER_WORD` = 4;
  - `LANE_W` = 2.
- Single module with no sub-module. The capture lane delay line (depth RAM_LATENCY) is a local shift register.

## Test plan
Use a behavioural 2K×8 RAM model with configurable latency.
1. Assert `resetn`=0 → `mem_ready`=0, `ram_ce`=0, `ram_wre`=0, `mem_rdata`=0x0000_0000, `ram_oce`=1.
2. Write addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF → RAM[0x10..0x13] = EF, BE, AD, DE; `mem_ready` pulses in cycle 5 only.
3. Read addr 0x10 → `mem_rdata`=0xDEADBEEF with `mem_ready` in cycle 6 (RAM_LATENCY=1). Repeat with RAM_LATENCY=2 → ready in cycle 7.
4. Write addr 0x10, wdata 0x0055_0000, wstrb 4'b0100 → only RAM[0x12] changes; readback gives 0xDE55BEEF, and `ram_ce` is low in cycles 1, 2 and 4.
5. Read addr 0xFFFF_F7FE (preloaded 0x7FC–0x7FF = 01, 02, 03, 04) → `ram_ad` sequence 0x7FC…0x7FF and `mem_rdata`=0x04030201. Hold `mem_valid` high through DONE → no second accept.
6. Drop `resetn` in cycle 3 of a read, then release → no `mem_ready` pulse and the state is IDLE. A subsequent read of 0x10 returns 0xDE55BEEF with normal latency.
